// File: rtl/m_pkt_packer_pkg.sv
// m_pkt_packer_pkg: beat types, packer FSM states and limits for the byte-to-beat packer
package m_pkt_packer_pkg;
    typedef logic [63:0] data_t;
    typedef logic [2:0]  len_t;
    typedef logic [7:0]  packet_word_off_t;
    typedef struct packed {
        logic  sop;
        logic  eop;
        len_t  length;
        data_t data;
    } in_t;
    typedef enum logic [1:0] {IDLE, BODY, DROP} packer_state_t;
    localparam int PACKER_MAX_WORDS = 256;
    function automatic logic [7:0] len_to_unary_mask(input len_t len);
        return 8'((9'd2 << len) - 9'd1);
    endfunction
endpackage

// File: rtl/m_pkt_packer_out_reg.sv
// m_pkt_out_reg: 1-entry valid/ready register slice for in_t beats (load/hold/drain)
module m_pkt_out_reg
    import m_pkt_packer_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic load_i,
    input  in_t  data_i,
    input  logic rdy_i,
    output logic vld_o,
    output in_t  data_o
);
    logic vld_q;
    in_t  data_q;
    // Load takes priority; otherwise a handshake empties the slot and data holds
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
        end else if (rdy_i) begin
            vld_q  <= 1'b0;
        end
    end
    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

// File: rtl/m_pkt_packer.sv
// m_pkt_packer: packs a byte valid/ready stream into 8B in_t beats; M_PKT_PACKER_TRUNC_EN caps packets at 256 beats
module m_pkt_packer
    import m_pkt_packer_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic       in_vld,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic       in_rdy,
    output logic       out_vld,
    output in_t        out,
    input  logic       out_rdy,
    output logic       err_trunc
);
    packer_state_t    st_q;
    in_t              stg_q, stg_d, nb, load_beat;
    logic [2:0]       cnt_q, cnt_d, base_cnt;
    logic             closed_q, closed_d, rdy_en_q;
    packet_word_off_t wc_q;
    logic             out_free, move, acc, full, trunc, close, load, beat_sop;
    data_t            base_data, nb_data;

    // Staging/close datapath: a closed staging beat moves out first, a fresh close goes straight out when free
    always_comb begin
        out_free  = ~out_vld | out_rdy;
        move      = closed_q & out_free;
        in_rdy    = rdy_en_q & ((st_q == DROP) | ~closed_q | out_free);
        acc       = in_vld & in_rdy & (st_q != DROP);
        base_cnt  = move ? 3'd0 : cnt_q;
        base_data = move ? '0 : stg_q.data;
        beat_sop  = (base_cnt == 3'd0) ? (st_q == IDLE) : stg_q.sop;
        nb_data   = base_data | (data_t'(in_byte) << {base_cnt, 3'b000});
        full      = base_cnt == 3'd7;
`ifdef M_PKT_PACKER_TRUNC_EN
        trunc     = full & ~in_last & ~beat_sop & (wc_q == packet_word_off_t'(PACKER_MAX_WORDS - 1));
`else
        trunc     = 1'b0;
`endif
        close     = acc & (full | in_last);
        nb        = '{sop: beat_sop, eop: in_last | trunc, length: base_cnt, data: nb_data};
        load      = move | (close & out_free);
        load_beat = move ? stg_q : nb;
        stg_d     = close ? ((out_free & ~move) ? '0 : nb)
                  : acc ? in_t'{sop: beat_sop, eop: 1'b0, length: 3'd0, data: nb_data}
                  : move ? '0 : stg_q;
        cnt_d     = (acc & ~close) ? base_cnt + 3'd1 : (close | move) ? 3'd0 : cnt_q;
        closed_d  = close ? ~(out_free & ~move) : closed_q & ~move;
    end

    // Staging register and post-reset ready enable
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stg_q    <= '0;
            cnt_q    <= '0;
            closed_q <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            stg_q    <= stg_d;
            cnt_q    <= cnt_d;
            closed_q <= closed_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Packet FSM and per-packet beat counter
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st_q <= IDLE;
            wc_q <= '0;
        end else begin
            if (in_vld & in_rdy)
                st_q <= (st_q == DROP) ? (in_last ? IDLE : DROP) : trunc ? DROP : in_last ? IDLE : BODY;
            if (close)
                wc_q <= beat_sop ? 8'd1 : wc_q + 8'd1;
        end
    end

`ifdef M_PKT_PACKER_TRUNC_EN
    logic err_q;
    // Sticky truncation flag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            err_q <= 1'b0;
        else if (close & trunc)
            err_q <= 1'b1;
    end
    assign err_trunc = err_q;
`else
    assign err_trunc = 1'b0;
`endif

    m_pkt_out_reg u_out (
        .clk    (clk),
        .arst_n (arst_n),
        .load_i (load),
        .data_i (load_beat),
        .rdy_i  (out_rdy),
        .vld_o  (out_vld),
        .data_o (out)
    );
endmodule

// File: tb/tb_m_pkt_packer.sv
// tb_m_pkt_packer: directed tests with a packet-level beat model and per-cycle output scoreboard
module tb_m_pkt_packer;
    import m_pkt_packer_pkg::*;
    typedef logic [7:0] bytes_t[$];
    typedef in_t beats_t[$];
`ifdef M_PKT_PACKER_TRUNC_EN
    localparam bit TRUNC = 1'b1;
`else
    localparam bit TRUNC = 1'b0;
`endif
    logic       clk = 1'b0, arst_n = 1'b0, in_vld = 1'b0, in_last = 1'b0, out_rdy = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_rdy, out_vld, err_trunc;
    in_t        out;
    int         checks = 0, errors = 0, stalls = 0, accepted = 0;
    in_t        exp_q[$];
    in_t        exp_b, hold_beat;
    logic       hold = 1'b0;
    bit         done = 1'b0;
    int         sz[6] = '{7, 8, 9, 16, 17, 1};

    m_pkt_packer dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_vld    (in_vld),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .out       (out),
        .out_rdy   (out_rdy),
        .err_trunc (err_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic chkb(input string name, input in_t got, input in_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic beats_t model(input bytes_t b);
        beats_t r;
        in_t    t;
        int     n, nb, k;
        n = b.size();
        if (TRUNC && n > PACKER_MAX_WORDS * 8) n = PACKER_MAX_WORDS * 8;
        nb = (n + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            t = '0;
            k = (n - i * 8 > 8) ? 8 : n - i * 8;
            t.sop = (i == 0);
            t.eop = (i == nb - 1);
            t.length = 3'(k - 1);
            for (int j = 0; j < k; j++) t.data[j*8 +: 8] = b[i*8 + j];
            r.push_back(t);
        end
        return r;
    endfunction

    function automatic bytes_t ramp(input int n, input logic [7:0] s);
        bytes_t r;
        for (int i = 0; i < n; i++) r.push_back(8'(int'(s) + i));
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic l);
        int t;
        t = 0;
        in_vld = 1'b1; in_byte = b; in_last = l;
        @(negedge clk);
        while (!in_rdy && t < 2000) begin
            stalls++; t++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout got in_rdy=0 want in_rdy=1");
            in_vld = 1'b0;
            return;
        end
        @(posedge clk); #1;
        accepted++;
        in_vld = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_pkt(input bytes_t b, input bit expect_it);
        beats_t m;
        if (expect_it) begin
            m = model(b);
            foreach (m[i]) exp_q.push_back(m[i]);
        end
        foreach (b[i]) send_byte(b[i], i == b.size() - 1);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk); t++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        @(negedge clk); @(negedge clk);
        chk({name, "_idle"}, 32'(out_vld), 0);
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (hold && arst_n) begin
            checks++;
            if (!(out_vld === 1'b1 && out === hold_beat)) begin
                errors++;
                $display("FAIL out_stable got vld=%b %h want %h", out_vld, out, hold_beat);
            end
        end
        hold = arst_n && out_vld && !out_rdy;
        hold_beat = out;
        if (arst_n && out_vld === 1'b1 && out_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got %h want none", out);
            end else begin
                exp_b = exp_q.pop_front();
                if (out !== exp_b) begin
                    errors++;
                    $display("FAIL beat got %h want %h", out, exp_b);
                end
            end
        end
    end

    initial begin
        bytes_t p;
        beats_t m;
        int     c;
        p = {8'hA5};
        m = model(p);
        chk("model_1B_n", m.size(), 1);
        chkb("model_1B", m[0], in_t'{sop: 1'b1, eop: 1'b1, length: 3'd0, data: 64'hA5});
        p = ramp(8, 8'h00);
        m = model(p);
        chk("model_8B_n", m.size(), 1);
        chkb("model_8B", m[0], in_t'{sop: 1'b1, eop: 1'b1, length: 3'd7, data: 64'h0706050403020100});
        p = ramp(11, 8'h00);
        m = model(p);
        chk("model_11B_n", m.size(), 2);
        chkb("model_11B_b0", m[0], in_t'{sop: 1'b1, eop: 1'b0, length: 3'd7, data: 64'h0706050403020100});
        chkb("model_11B_b1", m[1], in_t'{sop: 1'b0, eop: 1'b1, length: 3'd2, data: 64'h0A0908});

        #12;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_in_rdy", 32'(in_rdy), 0);
        chk("rst_err", 32'(err_trunc), 0);
        chkb("rst_out", out, '0);
        @(negedge clk); arst_n = 1'b1; #1;
        chk("rdy_before_edge", 32'(in_rdy), 0);
        @(negedge clk);
        chk("rdy_after_edge", 32'(in_rdy), 1);
        @(posedge clk); #1;

        p = {8'hA5};
        send_pkt(p, 1);
        drain("t1");

        p = ramp(8, 8'h00);
        send_pkt(p, 1);
        drain("t2");

        stalls = 0;
        p = ramp(11, 8'h10);
        send_pkt(p, 1);
        drain("t3");
        chk("t3_no_stall", stalls, 0);

        out_rdy = 1'b0;
        accepted = 0;
        p = ramp(20, 8'h40);
        fork
            send_pkt(p, 1);
            begin
                repeat (40) @(negedge clk);
                chk("t4_accepted", accepted, 16);
                chk("t4_in_rdy_low", 32'(in_rdy), 0);
                chk("t4_out_vld", 32'(out_vld), 1);
                @(posedge clk); #1;
                out_rdy = 1'b1;
            end
        join
        drain("t4");

        out_rdy = 1'b0;
        p = ramp(13, 8'h80);
        send_pkt(p, 0);
        #2 arst_n = 1'b0;
        #3;
        chk("t5_rst_vld", 32'(out_vld), 0);
        chk("t5_rst_rdy", 32'(in_rdy), 0);
        out_rdy = 1'b1;
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        p = ramp(3, 8'hC0);
        send_pkt(p, 1);
        drain("t5");
        chk("t5_err", 32'(err_trunc), 0);

        done = 1'b0;
        fork
            begin
                foreach (sz[k]) begin
                    p = ramp(sz[k], 8'(k * 32));
                    send_pkt(p, 1);
                end
                done = 1'b1;
            end
            begin
                c = 0;
                while (!done) begin
                    @(posedge clk); #1;
                    out_rdy = (c % 3 != 2);
                    c++;
                end
            end
        join
        out_rdy = 1'b1;
        drain("t7");

        stalls = 0;
        p = ramp(2100, 8'h00);
        send_pkt(p, 1);
        drain("t6");
        chk("t6_no_stall", stalls, 0);
        chk("t6_err", 32'(err_trunc), 32'(TRUNC));
        p = {8'h5A};
        send_pkt(p, 1);
        drain("t6_next");
        chk("t6_err_sticky", 32'(err_trunc), 32'(TRUNC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
